// File: rtl/rr_pkg.sv
// Shared constants, FSM state and report record type for the round-robin scheduler slice.
package rr_pkg;
  localparam int NO_P = 5;
  localparam int IDW  = 3;
  localparam int TW   = 16;
  localparam int SW   = TW + IDW;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT, ST_FINISHED} rr_state_e;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [TW-1:0]  turnaround;
    logic [TW-1:0]  waiting;
  } rr_rec_t;
endpackage

// File: rtl/rr_report_streamer.sv
// Walks the result table in id order and presents one registered record per
// accepted handshake; flags acceptance of the final record.
module rr_report_streamer #(
  parameter int NO_P = 5,
  parameter int IDW  = 3,
  parameter int TW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           go,
  input  logic [TW-1:0]  ta_tbl [NO_P],
  input  logic [TW-1:0]  wt_tbl [NO_P],
  input  logic           rpt_ready,
  output logic           rpt_valid,
  output logic [IDW-1:0] rpt_id,
  output logic [TW-1:0]  rpt_turnaround,
  output logic [TW-1:0]  rpt_waiting,
  output logic           last_accept
);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NO_P - 1);

  logic [IDW-1:0] idx_reg;
  logic           pending_reg;
  logic           load;

  // A new record may be loaded whenever the output slot is empty or being drained.
  assign load        = go && pending_reg && (!rpt_valid || rpt_ready);
  assign last_accept = rpt_valid && rpt_ready && !pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg        <= '0;
      pending_reg    <= 1'b1;
      rpt_valid      <= 1'b0;
      rpt_id         <= '0;
      rpt_turnaround <= '0;
      rpt_waiting    <= '0;
    end else if (clr) begin
      idx_reg        <= '0;
      pending_reg    <= 1'b1;
      rpt_valid      <= 1'b0;
      rpt_id         <= '0;
      rpt_turnaround <= '0;
      rpt_waiting    <= '0;
    end else if (load) begin
      rpt_valid      <= 1'b1;
      rpt_id         <= idx_reg;
      rpt_turnaround <= ta_tbl[idx_reg];
      rpt_waiting    <= wt_tbl[idx_reg];
      if (idx_reg == LAST_ID) begin
        pending_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rr_completion_monitor.sv
// Timestamps scheduler completion pulses, accumulates turnaround/waiting per
// process and streams a per-process report once every process has finished.
module rr_completion_monitor #(
  parameter int NO_P = rr_pkg::NO_P,
  parameter int IDW  = rr_pkg::IDW,
  parameter int TW   = rr_pkg::TW,
  parameter int SW   = TW + IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_id,
  input  logic [TW-1:0]  cfg_arrival,
  input  logic [TW-1:0]  cfg_burst,
  input  logic           start,
  input  logic           done_valid,
  input  logic [IDW-1:0] done_id,
  output logic           rpt_valid,
  input  logic           rpt_ready,
  output logic [IDW-1:0] rpt_id,
  output logic [TW-1:0]  rpt_turnaround,
  output logic [TW-1:0]  rpt_waiting,
  output logic [NO_P-1:0] done_mask,
  output logic [SW-1:0]  total_turnaround,
  output logic [SW-1:0]  total_waiting,
  output logic           all_done,
  output logic           err
);
  import rr_pkg::*;

  localparam logic [IDW:0]  NO_P_W = (IDW + 1)'(NO_P);
  localparam logic [TW-1:0] T_MAX  = '1;

  rr_state_e       state_reg, state_next;
  logic [TW-1:0]   timer_reg;
  logic [NO_P-1:0] done_mask_reg;
  logic [SW-1:0]   tot_ta_reg, tot_wt_reg;
  logic            err_reg;
  logic [TW-1:0]   arr_tbl [NO_P];
  logic [TW-1:0]   bst_tbl [NO_P];
  logic [TW-1:0]   ta_tbl  [NO_P];
  logic [TW-1:0]   wt_tbl  [NO_P];

  logic            idle_like, launch, id_ok, dup, take, last_done, last_accept;
  logic            ta_under, wt_under;
  logic [NO_P-1:0] id_bit, cfg_bit;
  logic [TW-1:0]   arr_sel, bst_sel, ta_val, wt_val;

  assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_FINISHED);
  assign launch    = start && idle_like;
  assign cfg_bit   = (cfg_we && idle_like && ({1'b0, cfg_id} < NO_P_W)) ?
                     (NO_P'(1) << cfg_id) : '0;
  assign id_ok     = {1'b0, done_id} < NO_P_W;
  assign id_bit    = id_ok ? (NO_P'(1) << done_id) : '0;
  assign dup       = |(done_mask_reg & id_bit);
  assign take      = (state_reg == ST_RUN) && done_valid && id_ok && !dup;
  assign arr_sel   = id_ok ? arr_tbl[done_id] : '0;
  assign bst_sel   = id_ok ? bst_tbl[done_id] : '0;

  // Both differences clamp at zero; the waiting term uses the clamped turnaround.
  assign ta_under  = timer_reg < arr_sel;
  assign ta_val    = ta_under ? '0 : timer_reg - arr_sel;
  assign wt_under  = ta_val < bst_sel;
  assign wt_val    = wt_under ? '0 : ta_val - bst_sel;
  assign last_done = take && (&(done_mask_reg | id_bit));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_FINISHED: if (start) state_next = ST_RUN;
      ST_RUN:               if (last_done) state_next = ST_REPORT;
      ST_REPORT:            if (last_accept) state_next = ST_FINISHED;
      default:              state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      done_mask_reg <= '0;
      tot_ta_reg    <= '0;
      tot_wt_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        timer_reg     <= '0;
        done_mask_reg <= '0;
        tot_ta_reg    <= '0;
        tot_wt_reg    <= '0;
        err_reg       <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        if (timer_reg != T_MAX) timer_reg <= timer_reg + 1'b1;
        if (take) begin
          done_mask_reg <= done_mask_reg | id_bit;
          tot_ta_reg    <= tot_ta_reg + SW'(ta_val);
          tot_wt_reg    <= tot_wt_reg + SW'(wt_val);
          if (ta_under || wt_under) err_reg <= 1'b1;
        end else if (done_valid) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  // Per-process configuration and result entries.
  generate
    for (genvar gi = 0; gi < NO_P; gi++) begin : g_proc
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          arr_tbl[gi] <= '0;
          bst_tbl[gi] <= '0;
          ta_tbl[gi]  <= '0;
          wt_tbl[gi]  <= '0;
        end else begin
          if (cfg_bit[gi]) begin
            arr_tbl[gi] <= cfg_arrival;
            bst_tbl[gi] <= cfg_burst;
          end
          if (launch) begin
            ta_tbl[gi] <= '0;
            wt_tbl[gi] <= '0;
          end else if (take && id_bit[gi]) begin
            ta_tbl[gi] <= ta_val;
            wt_tbl[gi] <= wt_val;
          end
        end
      end
    end
  endgenerate

  rr_report_streamer #(
    .NO_P (NO_P),
    .IDW  (IDW),
    .TW   (TW)
  ) u_streamer (
    .clk            (clk),
    .rst            (rst),
    .clr            (launch),
    .go             (state_reg == ST_REPORT),
    .ta_tbl         (ta_tbl),
    .wt_tbl         (wt_tbl),
    .rpt_ready      (rpt_ready),
    .rpt_valid      (rpt_valid),
    .rpt_id         (rpt_id),
    .rpt_turnaround (rpt_turnaround),
    .rpt_waiting    (rpt_waiting),
    .last_accept    (last_accept)
  );

  assign done_mask        = done_mask_reg;
  assign total_turnaround = tot_ta_reg;
  assign total_waiting    = tot_wt_reg;
  assign all_done         = (state_reg == ST_FINISHED);
  assign err              = err_reg;
endmodule

// File: tb/tb_rr_completion_monitor.sv
// Scoreboard bench for rr_completion_monitor: default instance plus a TW=4 instance for saturation.
`timescale 1ns/1ps
module tb_rr_completion_monitor;
  import rr_pkg::*;
  localparam int P = NO_P;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we, start, done_valid, rpt_ready;
  logic [IDW-1:0] cfg_id, done_id, rpt_id;
  logic [TW-1:0]  cfg_arrival, cfg_burst, rpt_turnaround, rpt_waiting;
  logic           rpt_valid, all_done, err;
  logic [P-1:0]   done_mask;
  logic [SW-1:0]  total_turnaround, total_waiting;

  logic           s_cfg_we, s_start, s_done_valid, s_rpt_ready;
  logic [IDW-1:0] s_cfg_id, s_done_id, s_rpt_id;
  logic [3:0]     s_cfg_arrival, s_cfg_burst, s_rpt_turnaround, s_rpt_waiting;
  logic           s_rpt_valid, s_all_done, s_err;
  logic [P-1:0]   s_done_mask;
  logic [6:0]     s_total_turnaround, s_total_waiting;

  int errors = 0;
  int checks = 0;
  int arr_m [P];
  int bst_m [P];
  int dt_m  [P];
  logic [P-1:0] mask_m;
  int tot_ta_m, tot_wt_m;
  logic err_m;
  rr_rec_t exp_q [$];

  always #5 clk = ~clk;

  rr_completion_monitor dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_arrival(cfg_arrival),
    .cfg_burst(cfg_burst), .start(start), .done_valid(done_valid), .done_id(done_id),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
    .rpt_turnaround(rpt_turnaround), .rpt_waiting(rpt_waiting), .done_mask(done_mask),
    .total_turnaround(total_turnaround), .total_waiting(total_waiting),
    .all_done(all_done), .err(err)
  );

  rr_completion_monitor #(.TW(4), .SW(7)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_id(s_cfg_id), .cfg_arrival(s_cfg_arrival),
    .cfg_burst(s_cfg_burst), .start(s_start), .done_valid(s_done_valid), .done_id(s_done_id),
    .rpt_valid(s_rpt_valid), .rpt_ready(s_rpt_ready), .rpt_id(s_rpt_id),
    .rpt_turnaround(s_rpt_turnaround), .rpt_waiting(s_rpt_waiting), .done_mask(s_done_mask),
    .total_turnaround(s_total_turnaround), .total_waiting(s_total_waiting),
    .all_done(s_all_done), .err(s_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion within 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input int id, input int a, input int b);
    cfg_we = 1'b1; cfg_id = IDW'(id); cfg_arrival = TW'(a); cfg_burst = TW'(b);
    @(negedge clk);
    cfg_we = 1'b0;
    if (id < P) begin arr_m[id] = a; bst_m[id] = b; end
  endtask

  task automatic cfg_baseline();
    cfg_write(0, 0, 8); cfg_write(1, 0, 9); cfg_write(2, 0, 11);
    cfg_write(3, 0, 5); cfg_write(4, 0, 4);
  endtask

  // Runs one schedule from dt_m; xk injects one extra event at timer xt:
  // 1 duplicate id 2, 2 id 6, 3 start, 4 config write.
  task automatic run_sched(input int xt, input int xk);
    int ta_m [P];
    int wt_m [P];
    int tmax, ta, wt;
    logic hit;
    mask_m = '0; tot_ta_m = 0; tot_wt_m = 0; err_m = 1'b0; tmax = 0;
    for (int i = 0; i < P; i++) if (dt_m[i] > tmax) tmax = dt_m[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t <= tmax; t++) begin
      hit = 1'b0;
      for (int i = 0; i < P; i++) begin
        if (dt_m[i] == t) begin
          done_valid = 1'b1; done_id = IDW'(i); hit = 1'b1;
          ta = (t < arr_m[i]) ? 0 : t - arr_m[i];
          wt = (ta < bst_m[i]) ? 0 : ta - bst_m[i];
          if (t < arr_m[i] || ta < bst_m[i]) err_m = 1'b1;
          ta_m[i] = ta; wt_m[i] = wt; mask_m[i] = 1'b1;
          tot_ta_m += ta; tot_wt_m += wt;
        end
      end
      if (t == xt) begin
        case (xk)
          1: begin done_valid = 1'b1; done_id = IDW'(2); err_m = 1'b1; end
          2: begin done_valid = 1'b1; done_id = IDW'(6); err_m = 1'b1; end
          3: start = 1'b1;
          4: begin cfg_we = 1'b1; cfg_id = '0; cfg_arrival = TW'(7); cfg_burst = TW'(1); end
          default: ;
        endcase
      end
      @(negedge clk);
      done_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
      if (hit || t == xt) begin
        checks++;
        if (done_mask !== mask_m) begin
          errors++;
          $display("FAIL mask t=%0d: got %b want %b", t, done_mask, mask_m);
        end
        checks++;
        if (err !== err_m) begin
          errors++;
          $display("FAIL err t=%0d: got %b want %b", t, err, err_m);
        end
      end
    end
    for (int i = 0; i < P; i++)
      exp_q.push_back({IDW'(i), TW'(ta_m[i]), TW'(wt_m[i])});
  endtask

  // Consumes up to max_acc records; mode 0 holds ready high, mode 1 toggles 1,0,0.
  task automatic drain(input int mode, input int max_acc);
    int k, acc, first, lastc;
    logic stalled;
    rr_rec_t held, got, e;
    k = 0; acc = 0; first = -1; lastc = -1; stalled = 1'b0; held = '0;
    while (acc < max_acc && k < 200) begin
      rpt_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      got = {rpt_id, rpt_turnaround, rpt_waiting};
      if (stalled) begin
        checks++;
        if (rpt_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL hold: got v=%b id=%0d ta=%0d wt=%0d want v=1 id=%0d ta=%0d wt=%0d",
                   rpt_valid, got.id, got.turnaround, got.waiting,
                   held.id, held.turnaround, held.waiting);
        end
      end
      stalled = rpt_valid && !rpt_ready;
      held = got;
      if (rpt_valid && rpt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra record: got id=%0d, required none", got.id);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rec: got id=%0d ta=%0d wt=%0d want id=%0d ta=%0d wt=%0d",
                     got.id, got.turnaround, got.waiting, e.id, e.turnaround, e.waiting);
          end
        end
        if (first < 0) first = k;
        lastc = k; acc++;
      end
      @(negedge clk);
      k++;
    end
    rpt_ready = 1'b0;
    checks++;
    if (acc < max_acc) begin
      errors++;
      $display("FAIL drain timeout: got %0d records, required %0d", acc, max_acc);
    end
    if (mode == 0 && max_acc == P && acc == P) begin
      checks++;
      if (lastc - first != P - 1) begin
        errors++;
        $display("FAIL streaming: got span %0d cycles, required %0d", lastc - first + 1, P);
      end
    end
  endtask

  task automatic check_finished(input string tag);
    checks++;
    if (rpt_valid !== 1'b0 || all_done !== 1'b1 || done_mask !== {P{1'b1}}) begin
      errors++;
      $display("FAIL %s end: got v=%b all_done=%b mask=%b want v=0 all_done=1 mask=11111",
               tag, rpt_valid, all_done, done_mask);
    end
    checks++;
    if (total_turnaround !== SW'(tot_ta_m) || total_waiting !== SW'(tot_wt_m)) begin
      errors++;
      $display("FAIL %s totals: got %0d/%0d want %0d/%0d", tag,
               total_turnaround, total_waiting, tot_ta_m, tot_wt_m);
    end
    checks++;
    if (err !== err_m || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s err/queue: got err=%b left=%0d want err=%b left=0", tag,
               err, exp_q.size(), err_m);
    end
    $display("%s: totals %0d/%0d err=%b", tag, total_turnaround, total_waiting, err);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (rpt_valid !== 1'b0 || rpt_id !== '0 || rpt_turnaround !== '0 || rpt_waiting !== '0 ||
        done_mask !== '0 || total_turnaround !== '0 || total_waiting !== '0 ||
        all_done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%b id=%0d ta=%0d wt=%0d mask=%b tot=%0d/%0d done=%b err=%b, required all 0",
               tag, rpt_valid, rpt_id, rpt_turnaround, rpt_waiting, done_mask,
               total_turnaround, total_waiting, all_done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < P; i++) begin arr_m[i] = 0; bst_m[i] = 0; end
  endtask

  task automatic test_baseline();
    cfg_baseline();
    dt_m = '{29, 32, 37, 26, 27};
    run_sched(-1, 0);
    checks++;
    if (all_done !== 1'b0) begin
      errors++;
      $display("FAIL all_done in REPORT: got %b want 0", all_done);
    end
    drain(0, P);
    check_finished("baseline");
    checks++;
    if (total_turnaround !== SW'(151) || total_waiting !== SW'(114)) begin
      errors++;
      $display("FAIL baseline literal totals: got %0d/%0d want 151/114",
               total_turnaround, total_waiting);
    end
  endtask

  task automatic test_backpressure();
    dt_m = '{29, 32, 37, 26, 27};
    run_sched(-1, 0);
    drain(1, P);
    check_finished("backpressure");
  endtask

  task automatic test_errors();
    dt_m = '{29, 32, 20, 26, 27};
    run_sched(25, 1);
    drain(0, P);
    check_finished("dup_id");
    dt_m = '{29, 32, 37, 26, 27};
    run_sched(10, 2);
    drain(0, P);
    check_finished("bad_id");
    cfg_write(0, 10, 8);
    dt_m = '{4, 32, 37, 26, 27};
    run_sched(-1, 0);
    drain(0, P);
    check_finished("early_done");
    cfg_write(0, 0, 8);
  endtask

  task automatic test_ignored();
    dt_m = '{29, 32, 37, 26, 27};
    run_sched(15, 3);
    drain(0, P);
    check_finished("start_in_run");
    run_sched(12, 4);
    drain(0, P);
    check_finished("cfg_in_run");
  endtask

  task automatic test_reset_mid_report();
    dt_m = '{29, 32, 37, 26, 27};
    run_sched(-1, 0);
    drain(0, 2);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_report");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < P; i++) begin arr_m[i] = 0; bst_m[i] = 0; end
    @(negedge clk);
    cfg_baseline();
    run_sched(-1, 0);
    drain(0, P);
    check_finished("after_reset");
  endtask

  task automatic test_timer_saturation();
    int n, k;
    s_cfg_we = 1'b1; s_cfg_id = '0; s_cfg_arrival = 4'd0; s_cfg_burst = 4'd3;
    @(negedge clk);
    s_cfg_we = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int t = 0; t <= 24; t++) begin
      if (t >= 20) begin s_done_valid = 1'b1; s_done_id = IDW'(t - 20); end
      @(negedge clk);
      s_done_valid = 1'b0;
    end
    n = 0; k = 0;
    s_rpt_ready = 1'b1;
    while (n < P && k < 50) begin
      if (s_rpt_valid) begin
        checks++;
        if (s_rpt_id !== IDW'(n) || s_rpt_turnaround !== 4'd15 ||
            s_rpt_waiting !== ((n == 0) ? 4'd12 : 4'd15)) begin
          errors++;
          $display("FAIL sat rec %0d: got id=%0d ta=%0d wt=%0d want id=%0d ta=15 wt=%0d",
                   n, s_rpt_id, s_rpt_turnaround, s_rpt_waiting, n, (n == 0) ? 12 : 15);
        end
        n++;
      end
      @(negedge clk);
      k++;
    end
    s_rpt_ready = 1'b0;
    checks++;
    if (n != P || s_total_turnaround !== 7'd75 || s_total_waiting !== 7'd72 ||
        s_err !== 1'b0 || s_all_done !== 1'b1) begin
      errors++;
      $display("FAIL sat end: got recs=%0d tot=%0d/%0d err=%b done=%b want 5 75/72 0 1",
               n, s_total_turnaround, s_total_waiting, s_err, s_all_done);
    end
    $display("timer_saturation: totals %0d/%0d", s_total_turnaround, s_total_waiting);
  endtask

  initial begin
    cfg_we = 1'b0; cfg_id = '0; cfg_arrival = '0; cfg_burst = '0;
    start = 1'b0; done_valid = 1'b0; done_id = '0; rpt_ready = 1'b0;
    s_cfg_we = 1'b0; s_cfg_id = '0; s_cfg_arrival = '0; s_cfg_burst = '0;
    s_start = 1'b0; s_done_valid = 1'b0; s_done_id = '0; s_rpt_ready = 1'b0;
    test_reset();
    test_baseline();
    test_backpressure();
    test_errors();
    test_ignored();
    test_reset_mid_report();
    test_timer_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
